// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Optional feature macro used by the top: WB_PERF_EN (conflict cycle counter).
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_AW         = 5;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned FP_BANK_OFFSET = 32;
    localparam int unsigned ENTRY_W        = REG_AW + DATA_W + 1;

    // Write-back source; SRC_NONE marks a cycle without a grant.
    typedef enum logic [1:0] {
        SRC_INT  = 2'd0,
        SRC_FPU  = 2'd1,
        SRC_LD   = 2'd2,
        SRC_NONE = 2'd3
    } src_t;

    // Round-robin pointer between the two buffered sources.
    typedef enum logic {
        RR_FPU = 1'b0,
        RR_LD  = 1'b1
    } rr_t;

    // One buffered write: destination, data, FP-bank select.
    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              fl;
    } wb_entry_t;

    // Flat register-file index: FP bank occupies the upper 32 entries.
    function automatic logic [REG_AW:0] rfIndex(input logic fl, input logic [REG_AW-1:0] wa);
        logic [REG_AW:0] offset;
        offset = fl ? (REG_AW + 1)'(FP_BANK_OFFSET) : '0;
        return offset + {1'b0, wa};
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the producers (integer pipe, FPU, load unit),
// the arbiter and the register file write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned CNTW = 16
);
    import regfile_wb_arbiter_pkg::*;

    logic              int_valid;
    logic [REG_AW-1:0] int_wa;
    logic [DATA_W-1:0] int_wd;
    logic              int_float;

    logic              fpu_valid;
    logic              fpu_ready;
    logic [REG_AW-1:0] fpu_wa;
    logic [DATA_W-1:0] fpu_wd;
    logic              fpu_float;

    logic              ld_valid;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_wa;
    logic [DATA_W-1:0] ld_wd;
    logic              ld_float;

    logic              rf_wen;
    logic [REG_AW-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic              rf_floating;

    logic              idle;
    logic [CNTW-1:0]   conflict_cycles;

    modport master (
        output int_valid, int_wa, int_wd, int_float,
        output fpu_valid, fpu_wa, fpu_wd, fpu_float,
        output ld_valid, ld_wa, ld_wd, ld_float,
        input  fpu_ready, ld_ready,
        input  rf_wen, rf_wa, rf_wd, rf_floating,
        input  idle, conflict_cycles
    );

    modport slave (
        input  int_valid, int_wa, int_wd, int_float,
        input  fpu_valid, fpu_wa, fpu_wd, fpu_float,
        input  ld_valid, ld_wa, ld_wd, ld_float,
        output fpu_ready, ld_ready,
        output rf_wen, rf_wa, rf_wd, rf_floating,
        output idle, conflict_cycles
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Synchronous FIFO of write-back entries (wa, wd, float); no fall-through.
// full is derived from the registered count only.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  wb_entry_t                   pushData,
    input  logic                        pop,
    output wb_entry_t                   popData,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(QDEPTH):0]     count
);

    localparam int unsigned PTRW = $clog2(QDEPTH);

    wb_entry_t        mem [QDEPTH];
    logic [PTRW-1:0]  wrPtr;
    logic [PTRW-1:0]  rdPtr;
    logic [PTRW:0]    used;
    logic             doPush;
    logic             doPop;

    assign full    = (used == (PTRW + 1)'(QDEPTH));
    assign empty   = (used == '0);
    assign count   = used;
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    // Pointers wrap naturally at the power-of-2 depth; count tracks occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            used  <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: integer pipe has absolute priority,
// FPU and load results are buffered and drained round-robin into one
// registered write per cycle.
// Optional macro WB_PERF_EN: builds the saturating conflict_cycles counter.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned CNTW   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    rr_t               rrState;
    rr_t               rrNext;
    src_t              grantSrc;

    wb_entry_t         fpuHead;
    wb_entry_t         ldHead;
    wb_entry_t         grantEntry;
    logic              fpuFull, fpuEmpty, ldFull, ldEmpty;
    logic [CW-1:0]     fpuCount, ldCount;
    logic              fpuPush, ldPush, fpuPop, ldPop;
    logic              intLive;

    logic              rfWen;
    logic [REG_AW-1:0] rfWa;
    logic [DATA_W-1:0] rfWd;
    logic              rfFloating;

    // Address 0 is handshaken normally but never enqueued or granted.
    assign intLive = bus.int_valid && (bus.int_wa != '0);
    assign fpuPush = bus.fpu_valid && !fpuFull && (bus.fpu_wa != '0);
    assign ldPush  = bus.ld_valid  && !ldFull  && (bus.ld_wa  != '0);

    assign bus.fpu_ready = !fpuFull;
    assign bus.ld_ready  = !ldFull;

    wb_fifo #(.QDEPTH(QDEPTH)) uFpuFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fpuPush),
        .pushData ('{wa: bus.fpu_wa, wd: bus.fpu_wd, fl: bus.fpu_float}),
        .pop      (fpuPop),
        .popData  (fpuHead),
        .full     (fpuFull),
        .empty    (fpuEmpty),
        .count    (fpuCount)
    );

    wb_fifo #(.QDEPTH(QDEPTH)) uLdFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (ldPush),
        .pushData ('{wa: bus.ld_wa, wd: bus.ld_wd, fl: bus.ld_float}),
        .pop      (ldPop),
        .popData  (ldHead),
        .full     (ldFull),
        .empty    (ldEmpty),
        .count    (ldCount)
    );

    // Round-robin pointer register.
    always_ff @(posedge clock) begin
        if (reset) rrState <= RR_FPU;
        else       rrState <= rrNext;
    end

    // Grant selection; after any FIFO grant the pointer favours the other source,
    // which covers both the contended toggle and the single-source hand-off.
    always_comb begin
        grantSrc = SRC_NONE;
        rrNext   = rrState;
        if (intLive)
            grantSrc = SRC_INT;
        else if (!fpuEmpty && !ldEmpty)
            grantSrc = (rrState == RR_FPU) ? SRC_FPU : SRC_LD;
        else if (!fpuEmpty)
            grantSrc = SRC_FPU;
        else if (!ldEmpty)
            grantSrc = SRC_LD;
        if (grantSrc == SRC_FPU) rrNext = RR_LD;
        if (grantSrc == SRC_LD)  rrNext = RR_FPU;
    end

    // Pop strobes and the write selected for this cycle.
    always_comb begin
        fpuPop     = (grantSrc == SRC_FPU);
        ldPop      = (grantSrc == SRC_LD);
        grantEntry = '{wa: bus.int_wa, wd: bus.int_wd, fl: bus.int_float};
        if (grantSrc == SRC_FPU) grantEntry = fpuHead;
        if (grantSrc == SRC_LD)  grantEntry = ldHead;
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            rfWen      <= 1'b0;
            rfWa       <= '0;
            rfWd       <= '0;
            rfFloating <= 1'b0;
        end else begin
            rfWen <= (grantSrc != SRC_NONE);
            if (grantSrc != SRC_NONE) begin
                rfWa       <= grantEntry.wa;
                rfWd       <= grantEntry.wd;
                rfFloating <= grantEntry.fl;
            end
        end
    end

    assign bus.rf_wen      = rfWen;
    assign bus.rf_wa       = rfWa;
    assign bus.rf_wd       = rfWd;
    assign bus.rf_floating = rfFloating;
    assign bus.idle        = (fpuCount == '0) && (ldCount == '0) && !rfWen;

`ifdef WB_PERF_EN
    logic [CNTW-1:0] conflictCount;

    // Count cycles where the integer pipe blocks a pending buffered write.
    always_ff @(posedge clock) begin
        if (reset)
            conflictCount <= '0;
        else if ((grantSrc == SRC_INT) && (!fpuEmpty || !ldEmpty) && (conflictCount != '1))
            conflictCount <= conflictCount + 1'b1;
    end

    assign bus.conflict_cycles = conflictCount;
`else
    assign bus.conflict_cycles = '0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writer side of the register file's single write port (wen/wa/wd/floatingWB).
- Merges write-back results from three producers into one registered write per cycle: integer pipe, multi-cycle FPU, load unit.
- Integer pipe has absolute priority. FPU and load results are buffered in per-source FIFOs and drained round-robin.
- Sits between the execute/memory stages and the register file.

Parameters:
QDEPTH, 4, entries per FPU/load FIFO; power of 2, >=2
CNTW, 16, width of optional perf counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
int_valid  in  1  integer pipe write request (always accepted)
int_wa  in  5  integer pipe destination register
int_wd  in  32  integer pipe data
int_float  in  1  integer pipe targets FP bank
fpu_valid  in  1  FPU result valid
fpu_ready  out  1  FPU FIFO can accept
fpu_wa  in  5  FPU destination register
fpu_wd  in  32  FPU data
fpu_float  in  1  FPU targets FP bank
ld_valid  in  1  load result valid
ld_ready  out  1  load FIFO can accept
ld_wa  in  5  load destination register
ld_wd  in  32  load data
ld_float  in  1  load targets FP bank
rf_wen  out  1  register file write enable
rf_wa  out  5  register file write address
rf_wd  out  32  register file write data
rf_floating  out  1  selects FP bank (upper 32 entries)
idle  out  1  both FIFOs empty and rf_wen==0
conflict_cycles  out  CNTW  perf counter (see optional feature)

Behaviour:
- Reset (synchronous, clock edge with reset=1): FIFOs flushed (pending entries discarded), rr pointer=FPU, rf_wen=0, rf_wa=0, rf_wd=0, rf_floating=0, conflict_cycles=0. fpu_ready/ld_ready=1 from the first cycle after reset.
- Push: transfer on valid&&ready. ready = !full, computed from registered count only. A FIFO that is full and popped in the same cycle does not accept a push that cycle.
- Writes with wa==0, either bank, are accepted and discarded: never enqueued, never granted. The register file ignores address 0.
- Grant, each cycle:
  - int_valid && int_wa!=0 -> int.
  - else both FIFOs nonempty -> source at rr; rr toggles after the grant.
  - else the single nonempty FIFO, rr toggles to the other source.
  - else no grant.
- The granted FIFO pops its head that cycle.
- Output is registered, 1-cycle latency. The cycle after a grant: rf_wen=1 with the granted wa/wd/float. With no grant: rf_wen=0; rf_wa/rf_wd/rf_floating hold their last value.
- Per-source order is FIFO-preserved. Cross-source WAW ordering to the same register is not enforced here; issue logic guarantees it.
- A push into an empty FIFO is not grantable until the next cycle (no fall-through).
- A FIFO holding QDEPTH entries is full; counters wrap modulo QDEPTH with a separate count.
- idle is combinational from registered state.

Optional Feature:
WB_PERF_EN:
- Defined: conflict_cycles increments by 1, saturating at all-ones, on every cycle in which int is granted while at least one FIFO is nonempty.
- Undefined: conflict_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared package: source encoding constants (SRC_INT=0, SRC_FPU=1, SRC_LD=2), register address width 5, data width 32, FP bank offset 32.
- Sub-module wb_fifo: parameterised QDEPTH x 38-bit sync FIFO (wa, wd, float) with push/pop/full/empty/count. Instantiated twice.

Test Plan:
- Int only: int_valid, wa=5, wd=0xDEADBEEF, float=0 -> next cycle rf_wen=1, rf_wa=5, rf_wd=0xDEADBEEF, rf_floating=0.
- Contention: int writes r3 for 3 cycles while the FPU pushes f7=0x3F800000 -> FPU write appears on the 4th output cycle, rf_floating=1; conflict_cycles=2 with WB_PERF_EN (FPU entry waits cycles 2–3), 0 without.
- Round-robin: FPU pushes r1,r2 and load pushes r10,r11 in the same two cycles, no int -> output order r1,r10,r2,r11.
- Full: hold fpu_valid with no drain (int busy) -> fpu_ready drops after 4 accepts. The 5th is accepted only after a pop, and no entry is lost or duplicated.
- r0: int_valid wa=0, float=0 and ld wa=0, float=1 -> rf_wen stays 0, ld_ready unaffected, a queued FPU entry is granted instead.
- Reset mid-drain: 3 load entries queued, assert reset 1 cycle -> rf_wen=0 next cycle, idle=1, no queued entry is ever written.
